bus_arbiter_rr: RTL

//  Round-robin arbiter and transaction sequencer for the shared coherence bus and L2 port used by the cores.

---
 rtl/bus_arbiter_rr_pkg.sv | 21 ++
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 108 ++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin coherence-bus arbiter.
package bus_arb_pkg;

   localparam int MAX_CORES = 8;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ACCESS  = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

   function automatic logic [MAX_CORES-1:0] onehot(input int idx, input int n);
      logic [MAX_CORES-1:0] v;
      v = '0;
      if (idx >= 0 && idx < n && idx < MAX_CORES) begin
         v[idx[2:0]] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin winner selection, searching upward from last_owner+1.
module rr_picker
   import bus_arb_pkg::*;
#(
   parameter  int NUM_CORES = 2,
   localparam int IW        = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] i_req,
   input  logic [IW-1:0]        i_last_owner,
   output logic [IW-1:0]        o_winner,
   output logic                 o_any_req
);

   logic [IW-1:0] w_idx;

   // Walk candidates from farthest to nearest so the nearest requester after last_owner wins.
   always_comb begin
      o_winner = '0;
      w_idx    = '0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         w_idx = IW'((int'(i_last_owner) + k) % NUM_CORES);
         if (i_req[w_idx]) begin
            o_winner = w_idx;
         end
      end
   end

   assign o_any_req = |i_req;

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and transaction sequencer for the shared coherence bus / L2 port.
//
// state       | meaning
// ARB_IDLE    | bus free, waiting for any core request
// ARB_ACCESS  | one core owns the bus, hold counter running
// ARB_RELEASE | one-cycle turnaround, grant dropped, pointer updated
module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter  int NUM_CORES      = 2,
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int IW             = $clog2(NUM_CORES),
   localparam int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CORES-1:0] req_core,
   input  logic                 l2_done,
   output logic [NUM_CORES-1:0] grant_core,
   output logic [NUM_CORES-1:0] stall_core,
   output logic                 l2_valid,
   output logic                 bus_busy,
   output logic [IW-1:0]        owner_id,
   output logic                 timeout_err
);

   arb_state_t           r_state;
   logic [NUM_CORES-1:0] r_grant;
   logic                 r_l2_valid;
   logic [IW-1:0]        r_owner;
   logic [IW-1:0]        r_last;
   logic [CW-1:0]        r_cnt;
   logic                 r_tmo;

   logic [IW-1:0]        w_winner;
   logic                 w_any_req;
   logic [NUM_CORES-1:0] w_grant_next;
   logic                 w_owner_req;
   logic                 w_cnt_tc;

   rr_picker #(
      .NUM_CORES (NUM_CORES)
   ) u_picker (
      .i_req        (req_core),
      .i_last_owner (r_last),
      .o_winner     (w_winner),
      .o_any_req    (w_any_req)
   );

   assign w_grant_next = NUM_CORES'(onehot(int'(w_winner), NUM_CORES));
   assign w_owner_req  = req_core[r_owner];
   assign w_cnt_tc     = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ARB_IDLE;
         r_grant    <= '0;
         r_l2_valid <= 1'b0;
         r_owner    <= '0;
         r_last     <= IW'(NUM_CORES - 1);
         r_cnt      <= '0;
         r_tmo      <= 1'b0;
      end else begin
         r_tmo <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (w_any_req) begin
                  r_grant    <= w_grant_next;
                  r_l2_valid <= 1'b1;
                  r_owner    <= w_winner;
                  r_cnt      <= '0;
                  r_state    <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               // Completion has priority over abort and timeout; only a true timeout flags an error.
               if (l2_done || !w_owner_req || w_cnt_tc) begin
                  r_grant    <= '0;
                  r_l2_valid <= 1'b0;
                  r_cnt      <= '0;
                  r_state    <= ARB_RELEASE;
                  r_tmo      <= !l2_done && w_owner_req;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ARB_RELEASE: begin
               r_last  <= r_owner;
               r_state <= ARB_IDLE;
            end
            default: begin
               r_grant    <= '0;
               r_l2_valid <= 1'b0;
               r_cnt      <= '0;
               r_state    <= ARB_IDLE;
            end
         endcase
      end
   end

   assign grant_core  = r_grant;
   assign l2_valid    = r_l2_valid;
   assign bus_busy    = (r_state != ARB_IDLE);
   assign owner_id    = r_owner;
   assign timeout_err = r_tmo;
   assign stall_core  = req_core & ~r_grant;

endmodule
